// File: rtl/wb_fec.sv
// FEC shim between two fabric streams: the encoder path rewrites the destination MAC of
// each frame, the decoder path passes through or sinks. A pipelined Wishbone slave holds config.

module wb_fec_path #(
   parameter bit g_pass = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        rewrite_i,
   input  logic [47:0] mac_i,
   input  logic        sink_cyc_i,
   input  logic        sink_stb_i,
   input  logic        sink_we_i,
   input  logic [1:0]  sink_sel_i,
   input  logic [1:0]  sink_adr_i,
   input  logic [15:0] sink_dat_i,
   output logic        sink_stall_o,
   output logic        sink_ack_o,
   output logic        src_cyc_o,
   output logic        src_stb_o,
   output logic        src_we_o,
   output logic [1:0]  src_sel_o,
   output logic [1:0]  src_adr_o,
   output logic [15:0] src_dat_o,
   input  logic        src_stall_i,
   output logic        frame_done_o
);
   logic        cyc_prev_q, cyc_prev_d;
   logic        in_frame_q, in_frame_d;
   logic        rewrite_q, rewrite_d;
   logic [47:0] mac_q, mac_d;
   logic [1:0]  didx_q, didx_d;
   logic        ack_q, ack_d;
   logic        src_cyc_q, src_cyc_d;
   logic        src_stb_q, src_stb_d;
   logic        src_we_q, src_we_d;
   logic [1:0]  src_sel_q, src_sel_d;
   logic [1:0]  src_adr_q, src_adr_d;
   logic [15:0] src_dat_q, src_dat_d;

   logic        frame_start, frame_end, stall, accept, rewrite_eff;
   logic [47:0] mac_eff;
   logic [1:0]  didx_eff;
   logic [15:0] word_dat;

   always_comb begin
      frame_start = sink_cyc_i & ~cyc_prev_q;
      frame_end   = ~sink_cyc_i & cyc_prev_q;
      // The first word may arrive on the same cycle cyc rises, so use the fresh latch values then.
      rewrite_eff = frame_start ? rewrite_i : rewrite_q;
      mac_eff     = frame_start ? mac_i : mac_q;
      didx_eff    = frame_start ? 2'd0 : didx_q;
      stall       = g_pass ? (src_stb_q & src_stall_i) : 1'b0;
      accept      = sink_cyc_i & sink_stb_i & ~stall;

      cyc_prev_d  = sink_cyc_i;
      in_frame_d  = frame_start ? 1'b1 : (frame_end ? 1'b0 : in_frame_q);
      rewrite_d   = rewrite_eff;
      mac_d       = mac_eff;
      didx_d      = didx_eff;
      ack_d       = accept;
      word_dat    = sink_dat_i;

      if (accept && sink_adr_i == 2'd0) begin
         if (rewrite_eff) begin
            case (didx_eff)
               2'd0:    word_dat = mac_eff[47:32];
               2'd1:    word_dat = mac_eff[31:16];
               2'd2:    word_dat = mac_eff[15:0];
               default: word_dat = sink_dat_i;
            endcase
         end
         if (didx_eff != 2'd3) didx_d = didx_eff + 2'd1;
      end

      src_stb_d = src_stb_q & src_stall_i;
      src_we_d  = src_we_q;
      src_sel_d = src_sel_q;
      src_adr_d = src_adr_q;
      src_dat_d = src_dat_q;
      if (g_pass && accept) begin
         src_stb_d = 1'b1;
         src_we_d  = sink_we_i;
         src_sel_d = sink_sel_i;
         src_adr_d = sink_adr_i;
         src_dat_d = word_dat;
      end
      // Keep cyc asserted until the last buffered word has been taken downstream.
      src_cyc_d = g_pass & (sink_cyc_i | src_stb_d);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // Assume a frame may already be running so a cyc still high after reset is not a start.
         cyc_prev_q <= 1'b1;
         in_frame_q <= 1'b0;
         rewrite_q  <= 1'b0;
         mac_q      <= 48'h0;
         didx_q     <= 2'd0;
         ack_q      <= 1'b0;
         src_cyc_q  <= 1'b0;
         src_stb_q  <= 1'b0;
         src_we_q   <= 1'b0;
         src_sel_q  <= 2'd0;
         src_adr_q  <= 2'd0;
         src_dat_q  <= 16'h0;
      end else begin
         cyc_prev_q <= cyc_prev_d;
         in_frame_q <= in_frame_d;
         rewrite_q  <= rewrite_d;
         mac_q      <= mac_d;
         didx_q     <= didx_d;
         ack_q      <= ack_d;
         src_cyc_q  <= src_cyc_d;
         src_stb_q  <= src_stb_d;
         src_we_q   <= src_we_d;
         src_sel_q  <= src_sel_d;
         src_adr_q  <= src_adr_d;
         src_dat_q  <= src_dat_d;
      end
   end

   assign sink_stall_o = stall;
   assign sink_ack_o   = ack_q;
   assign src_cyc_o    = src_cyc_q;
   assign src_stb_o    = src_stb_q;
   assign src_we_o     = src_we_q;
   assign src_sel_o    = src_sel_q;
   assign src_adr_o    = src_adr_q;
   assign src_dat_o    = src_dat_q;
   assign frame_done_o = frame_end & in_frame_q;
endmodule

module wb_fec #(
   parameter bit g_en_fec_enc  = 1'b1,
   parameter bit g_en_fec_dec  = 1'b1,
   parameter bit g_en_golay    = 1'b0,
   parameter bit g_en_dec_time = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        fec_enc_sink_cyc,
   input  logic        fec_enc_sink_stb,
   input  logic        fec_enc_sink_we,
   input  logic [1:0]  fec_enc_sink_sel,
   input  logic [1:0]  fec_enc_sink_adr,
   input  logic [15:0] fec_enc_sink_dat,
   output logic        fec_enc_sink_stall,
   output logic        fec_enc_sink_ack,
   output logic        fec_enc_src_cyc,
   output logic        fec_enc_src_stb,
   output logic        fec_enc_src_we,
   output logic [1:0]  fec_enc_src_sel,
   output logic [1:0]  fec_enc_src_adr,
   output logic [15:0] fec_enc_src_dat,
   input  logic        fec_enc_src_stall,
   input  logic        fec_enc_src_ack,
   input  logic        fec_dec_sink_cyc,
   input  logic        fec_dec_sink_stb,
   input  logic        fec_dec_sink_we,
   input  logic [1:0]  fec_dec_sink_sel,
   input  logic [1:0]  fec_dec_sink_adr,
   input  logic [15:0] fec_dec_sink_dat,
   output logic        fec_dec_sink_stall,
   output logic        fec_dec_sink_ack,
   output logic        fec_dec_src_cyc,
   output logic        fec_dec_src_stb,
   output logic        fec_dec_src_we,
   output logic [1:0]  fec_dec_src_sel,
   output logic [1:0]  fec_dec_src_adr,
   output logic [15:0] fec_dec_src_dat,
   input  logic        fec_dec_src_stall,
   input  logic        fec_dec_src_ack,
   input  logic        wb_slave_cyc,
   input  logic        wb_slave_stb,
   input  logic        wb_slave_we,
   input  logic [3:0]  wb_slave_sel,
   input  logic [31:0] wb_slave_adr,
   input  logic [31:0] wb_slave_dat_i,
   output logic [31:0] wb_slave_dat_o,
   output logic        wb_slave_ack,
   output logic        wb_slave_stall
);
   // Golay coding and decode timestamping are reserved options with no hardware behind them.
   if (g_en_golay || g_en_dec_time) begin : g_reserved
   end

   logic        enc_en_q, enc_en_d;
   logic [15:0] dmac_hi_q, dmac_hi_d;
   logic [31:0] dmac_lo_q, dmac_lo_d;
   logic [31:0] enc_cnt_q, enc_cnt_d;
   logic [31:0] dec_cnt_q, dec_cnt_d;
   logic        wb_ack_q, wb_ack_d;
   logic [31:0] wb_dat_q, wb_dat_d;

   logic        wb_req, enc_done, dec_done;
   logic [31:0] rd_data;
   logic        unused_ok;

   assign unused_ok = ^{wb_slave_adr[31:5], wb_slave_adr[1:0], fec_enc_src_ack, fec_dec_src_ack};

   always_comb begin
      wb_req    = wb_slave_cyc & wb_slave_stb;
      enc_en_d  = enc_en_q;
      dmac_hi_d = dmac_hi_q;
      dmac_lo_d = dmac_lo_q;
      if (wb_req && wb_slave_we) begin
         case (wb_slave_adr[4:2])
            3'd0: if (wb_slave_sel[0]) enc_en_d = wb_slave_dat_i[0];
            3'd1: begin
               if (wb_slave_sel[0]) dmac_hi_d[7:0]  = wb_slave_dat_i[7:0];
               if (wb_slave_sel[1]) dmac_hi_d[15:8] = wb_slave_dat_i[15:8];
            end
            3'd2: begin
               for (int b = 0; b < 4; b++)
                  if (wb_slave_sel[b]) dmac_lo_d[8*b +: 8] = wb_slave_dat_i[8*b +: 8];
            end
            default: ;
         endcase
      end

      case (wb_slave_adr[4:2])
         3'd0:    rd_data = {31'h0, enc_en_q};
         3'd1:    rd_data = {16'h0, dmac_hi_q};
         3'd2:    rd_data = dmac_lo_q;
         3'd3:    rd_data = enc_cnt_q;
         3'd4:    rd_data = dec_cnt_q;
         default: rd_data = 32'h0;
      endcase
      wb_ack_d  = wb_req;
      wb_dat_d  = (wb_req && !wb_slave_we) ? rd_data : 32'h0;

      enc_cnt_d = enc_cnt_q + {31'h0, enc_done};
      dec_cnt_d = dec_cnt_q + {31'h0, dec_done};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         enc_en_q  <= g_en_fec_enc;
         dmac_hi_q <= 16'h1122;
         dmac_lo_q <= 32'h33445566;
         enc_cnt_q <= 32'h0;
         dec_cnt_q <= 32'h0;
         wb_ack_q  <= 1'b0;
         wb_dat_q  <= 32'h0;
      end else begin
         enc_en_q  <= enc_en_d;
         dmac_hi_q <= dmac_hi_d;
         dmac_lo_q <= dmac_lo_d;
         enc_cnt_q <= enc_cnt_d;
         dec_cnt_q <= dec_cnt_d;
         wb_ack_q  <= wb_ack_d;
         wb_dat_q  <= wb_dat_d;
      end
   end

   assign wb_slave_ack   = wb_ack_q;
   assign wb_slave_dat_o = wb_dat_q;
   assign wb_slave_stall = 1'b0;

   wb_fec_path #(.g_pass(1'b1)) u_enc (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .rewrite_i    (enc_en_q & g_en_fec_enc),
      .mac_i        ({dmac_hi_q, dmac_lo_q}),
      .sink_cyc_i   (fec_enc_sink_cyc),
      .sink_stb_i   (fec_enc_sink_stb),
      .sink_we_i    (fec_enc_sink_we),
      .sink_sel_i   (fec_enc_sink_sel),
      .sink_adr_i   (fec_enc_sink_adr),
      .sink_dat_i   (fec_enc_sink_dat),
      .sink_stall_o (fec_enc_sink_stall),
      .sink_ack_o   (fec_enc_sink_ack),
      .src_cyc_o    (fec_enc_src_cyc),
      .src_stb_o    (fec_enc_src_stb),
      .src_we_o     (fec_enc_src_we),
      .src_sel_o    (fec_enc_src_sel),
      .src_adr_o    (fec_enc_src_adr),
      .src_dat_o    (fec_enc_src_dat),
      .src_stall_i  (fec_enc_src_stall),
      .frame_done_o (enc_done)
   );

   wb_fec_path #(.g_pass(g_en_fec_dec)) u_dec (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .rewrite_i    (1'b0),
      .mac_i        (48'h0),
      .sink_cyc_i   (fec_dec_sink_cyc),
      .sink_stb_i   (fec_dec_sink_stb),
      .sink_we_i    (fec_dec_sink_we),
      .sink_sel_i   (fec_dec_sink_sel),
      .sink_adr_i   (fec_dec_sink_adr),
      .sink_dat_i   (fec_dec_sink_dat),
      .sink_stall_o (fec_dec_sink_stall),
      .sink_ack_o   (fec_dec_sink_ack),
      .src_cyc_o    (fec_dec_src_cyc),
      .src_stb_o    (fec_dec_src_stb),
      .src_we_o     (fec_dec_src_we),
      .src_sel_o    (fec_dec_src_sel),
      .src_adr_o    (fec_dec_src_adr),
      .src_dat_o    (fec_dec_src_dat),
      .src_stall_i  (fec_dec_src_stall),
      .frame_done_o (dec_done)
   );
endmodule

// File: tb/tb_wb_fec.sv
// Bench for wb_fec: frame-level model of the MAC rewrite, per-cycle output compare,
// Wishbone register checks and a decoder sink built with the decoder path disabled.

module tb_wb_fec;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        enc_cyc, enc_stb, enc_we;
  logic [1:0]  enc_sel, enc_adr;
  logic [15:0] enc_dat;
  logic        enc_sink_stall, enc_sink_ack;
  logic        enc_src_cyc, enc_src_stb, enc_src_we;
  logic [1:0]  enc_src_sel, enc_src_adr;
  logic [15:0] enc_src_dat;
  logic        enc_src_stall, enc_src_ack;
  logic        dec_cyc, dec_stb, dec_we;
  logic [1:0]  dec_sel, dec_adr;
  logic [15:0] dec_dat;
  logic        dec_sink_stall, dec_sink_ack;
  logic        dec_src_cyc, dec_src_stb, dec_src_we;
  logic [1:0]  dec_src_sel, dec_src_adr;
  logic [15:0] dec_src_dat;
  logic        dec_src_stall, dec_src_ack;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat_i, wb_dat_o;
  logic        wb_ack, wb_stall;

  wb_fec #(
    .g_en_fec_enc(1'b1), .g_en_fec_dec(1'b0), .g_en_golay(1'b0), .g_en_dec_time(1'b0)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .fec_enc_sink_cyc(enc_cyc), .fec_enc_sink_stb(enc_stb), .fec_enc_sink_we(enc_we),
    .fec_enc_sink_sel(enc_sel), .fec_enc_sink_adr(enc_adr), .fec_enc_sink_dat(enc_dat),
    .fec_enc_sink_stall(enc_sink_stall), .fec_enc_sink_ack(enc_sink_ack),
    .fec_enc_src_cyc(enc_src_cyc), .fec_enc_src_stb(enc_src_stb), .fec_enc_src_we(enc_src_we),
    .fec_enc_src_sel(enc_src_sel), .fec_enc_src_adr(enc_src_adr), .fec_enc_src_dat(enc_src_dat),
    .fec_enc_src_stall(enc_src_stall), .fec_enc_src_ack(enc_src_ack),
    .fec_dec_sink_cyc(dec_cyc), .fec_dec_sink_stb(dec_stb), .fec_dec_sink_we(dec_we),
    .fec_dec_sink_sel(dec_sel), .fec_dec_sink_adr(dec_adr), .fec_dec_sink_dat(dec_dat),
    .fec_dec_sink_stall(dec_sink_stall), .fec_dec_sink_ack(dec_sink_ack),
    .fec_dec_src_cyc(dec_src_cyc), .fec_dec_src_stb(dec_src_stb), .fec_dec_src_we(dec_src_we),
    .fec_dec_src_sel(dec_src_sel), .fec_dec_src_adr(dec_src_adr), .fec_dec_src_dat(dec_src_dat),
    .fec_dec_src_stall(dec_src_stall), .fec_dec_src_ack(dec_src_ack),
    .wb_slave_cyc(wb_cyc), .wb_slave_stb(wb_stb), .wb_slave_we(wb_we), .wb_slave_sel(wb_sel),
    .wb_slave_adr(wb_adr), .wb_slave_dat_i(wb_dat_i), .wb_slave_dat_o(wb_dat_o),
    .wb_slave_ack(wb_ack), .wb_slave_stall(wb_stall)
  );

  // Word packing used by model and scoreboard: {adr, sel, we, dat}
  int          n_checks = 0;
  int          n_err = 0;
  logic [20:0] exp_q[$];
  logic [20:0] frm_q[$];
  logic [15:0] out_log[$];
  bit          chk_en = 1'b0;
  bit          stall_rand = 1'b0;
  bit          acc_prev = 1'b0;
  logic        model_en;
  logic [47:0] model_mac;
  int          exp_enc_cnt = 0;
  int          dec_ack_cnt = 0;

  function automatic logic [20:0] pack(logic [1:0] adr, logic [1:0] sel, logic we, logic [15:0] dat);
    return {adr, sel, we, dat};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Random downstream backpressure
  initial begin
    enc_src_stall = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      enc_src_stall = stall_rand && ($urandom_range(0, 99) < 50);
    end
  end

  // Scoreboard: every word leaving the encoder must match the head of the expected queue
  always @(negedge clk) begin
    logic [20:0] got, e;
    if (rst || !chk_en) begin
      acc_prev = 1'b0;
    end else begin
      check("enc_sink_ack", {31'h0, enc_sink_ack}, {31'h0, acc_prev});
      acc_prev = enc_cyc & enc_stb & ~enc_sink_stall;
      check("enc_cyc_covers_stb", {31'h0, enc_src_cyc | ~enc_src_stb}, 32'h1);
      if (enc_src_stb && !enc_src_stall) begin
        got = pack(enc_src_adr, enc_src_sel, enc_src_we, enc_src_dat);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL enc_extra_word: got %h expected no word", got);
        end else begin
          e = exp_q.pop_front();
          check("enc_word", {11'h0, got}, {11'h0, e});
          if (got[20:19] == 2'd0) out_log.push_back(got[15:0]);
        end
      end
    end
    if (!rst) begin
      if (dec_sink_ack) dec_ack_cnt++;
      check("dec_src_idle", {30'h0, dec_src_cyc, dec_src_stb}, 32'h0);
    end
  end

  task automatic build_frame(input bit fixed_dst, input bit extras);
    frm_q.delete();
    if (extras && $urandom_range(0, 1) == 1) frm_q.push_back(pack(2'd2, 2'($urandom), 1'b1, 16'($urandom)));
    for (int i = 0; i < 3; i++) frm_q.push_back(pack(2'd0, 2'd3, 1'b1, fixed_dst ? 16'hFFFF : 16'($urandom)));
    frm_q.push_back(pack(2'd0, 2'd3, 1'b1, 16'h0102));
    frm_q.push_back(pack(2'd0, 2'd3, 1'b1, 16'h0304));
    frm_q.push_back(pack(2'd0, 2'd3, 1'b1, 16'h0506));
    frm_q.push_back(pack(2'd0, 2'd3, 1'b1, 16'h002E));
    for (int i = 0; i < 23; i++) frm_q.push_back(pack(2'd0, 2'd3, 1'b1, 16'($urandom)));
    if (extras && $urandom_range(0, 1) == 1) frm_q.push_back(pack(2'd1, 2'($urandom), 1'b1, 16'($urandom)));
  endtask

  // Sends frm_q into the encoder; the expected output is derived from the register state at frame start.
  task automatic send_enc();
    logic        rw;
    logic [47:0] mac, sh;
    logic [20:0] w, e;
    int          didx, guard;
    rw = model_en;
    mac = model_mac;
    didx = 0;
    @(posedge clk);
    #1;
    foreach (frm_q[i]) begin
      w = frm_q[i];
      enc_cyc = 1'b1;
      enc_stb = 1'b1;
      {enc_adr, enc_sel, enc_we, enc_dat} = w;
      guard = 0;
      forever begin
        @(negedge clk);
        if (!enc_sink_stall) break;
        guard++;
        if (guard > 500) begin
          $display("FAIL enc_sink_stall_timeout: stalled %0d cycles, expected accept", guard);
          $fatal(1, "encoder sink never accepted");
        end
        @(posedge clk);
        #1;
      end
      e = w;
      if (w[20:19] == 2'd0) begin
        if (rw && didx < 3) begin
          sh = mac >> (32 - 16 * didx);
          e[15:0] = sh[15:0];
        end
        didx++;
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
    end
    enc_stb = 1'b0;
    enc_cyc = 1'b0;
    exp_enc_cnt++;
  endtask

  task automatic send_dec();
    @(posedge clk);
    #1;
    foreach (frm_q[i]) begin
      dec_cyc = 1'b1;
      dec_stb = 1'b1;
      {dec_adr, dec_sel, dec_we, dec_dat} = frm_q[i];
      @(negedge clk);
      check("dec_sink_stall", {31'h0, dec_sink_stall}, 32'h0);
      @(posedge clk);
      #1;
    end
    dec_stb = 1'b0;
    dec_cyc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((exp_q.size() != 0 || enc_src_stb) && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("drain_left", exp_q.size(), 32'h0);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    @(posedge clk);
    #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 4'hF; wb_adr = adr; wb_dat_i = dat;
    @(posedge clk);
    #1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    check("wb_write_ack", {31'h0, wb_ack}, 32'h1);
    case (adr[4:2])
      3'd0: model_en = dat[0];
      3'd1: model_mac[47:32] = dat[15:0];
      3'd2: model_mac[31:0] = dat;
      default: ;
    endcase
  endtask

  task automatic check_rd(input string name, input logic [31:0] adr, input logic [31:0] exp);
    @(posedge clk);
    #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 4'hF; wb_adr = adr;
    @(posedge clk);
    #1;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    check("wb_read_ack", {31'h0, wb_ack}, 32'h1);
    check(name, wb_dat_o, exp);
  endtask

  task automatic check_dst(input string name, input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
    check({name, "_nwords"}, out_log.size(), 32'd30);
    if (out_log.size() >= 3) begin
      check({name, "_dst0"}, {16'h0, out_log[0]}, {16'h0, d0});
      check({name, "_dst1"}, {16'h0, out_log[1]}, {16'h0, d1});
      check({name, "_dst2"}, {16'h0, out_log[2]}, {16'h0, d2});
    end
  endtask

  initial begin
    {enc_cyc, enc_stb, enc_we, enc_sel, enc_adr, enc_dat} = '0;
    {dec_cyc, dec_stb, dec_we, dec_sel, dec_adr, dec_dat} = '0;
    {wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_i} = '0;
    enc_src_ack = 1'b0; dec_src_stall = 1'b0; dec_src_ack = 1'b0;
    model_en = 1'b1;
    model_mac = 48'h112233445566;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_enc_src_ctl", {29'h0, enc_src_cyc, enc_src_stb, enc_src_we}, 32'h0);
    check("rst_enc_src_data", {12'h0, enc_src_adr, enc_src_sel, enc_src_dat}, 32'h0);
    check("rst_enc_sink", {30'h0, enc_sink_stall, enc_sink_ack}, 32'h0);
    check("rst_wb", {30'h0, wb_ack, wb_stall}, 32'h0);
    check("rst_wb_dat", wb_dat_o, 32'h0);
    chk_en = 1'b1;

    check_rd("rd_enc_en", 32'h00, 32'h1);
    check_rd("rd_dmac_hi", 32'h04, 32'h1122);
    check_rd("rd_dmac_lo", 32'h08, 32'h33445566);
    check_rd("rd_enc_cnt0", 32'h0C, 32'h0);
    check_rd("rd_dec_cnt0", 32'h10, 32'h0);
    check_rd("rd_unmapped", 32'h14, 32'h0);

    // Default MAC rewrite
    out_log.delete();
    build_frame(1'b1, 1'b0);
    send_enc();
    wait_drain();
    check_dst("frame1", 16'h1122, 16'h3344, 16'h5566);
    check_rd("rd_enc_cnt1", 32'h0C, 32'd1);

    // Rewrite disabled, then a new low MAC word
    wb_write(32'h00, 32'h0);
    out_log.delete();
    build_frame(1'b1, 1'b0);
    send_enc();
    wait_drain();
    check_dst("no_rewrite", 16'hFFFF, 16'hFFFF, 16'hFFFF);
    wb_write(32'h00, 32'h1);
    wb_write(32'h08, 32'hAABBCCDD);
    out_log.delete();
    build_frame(1'b1, 1'b0);
    send_enc();
    wait_drain();
    check_dst("new_lo", 16'h1122, 16'hAABB, 16'hCCDD);

    // Back-to-back frames under random backpressure
    stall_rand = 1'b1;
    repeat (100) begin
      build_frame(1'b0, 1'b1);
      send_enc();
    end
    stall_rand = 1'b0;
    wait_drain();
    check_rd("rd_enc_cnt_model", 32'h0C, exp_enc_cnt);
    check_rd("rd_enc_cnt_103", 32'h0C, 32'd103);

    // MAC written mid-frame only applies from the next frame
    out_log.delete();
    build_frame(1'b1, 1'b0);
    fork
      send_enc();
      begin
        repeat (6) @(posedge clk);
        wb_write(32'h04, 32'h0000BEEF);
      end
    join
    wait_drain();
    check_dst("mid_old", 16'h1122, 16'hAABB, 16'hCCDD);
    out_log.delete();
    build_frame(1'b1, 1'b0);
    send_enc();
    wait_drain();
    check_dst("mid_new", 16'hBEEF, 16'hAABB, 16'hCCDD);

    // Decoder built as a discarding sink
    dec_ack_cnt = 0;
    build_frame(1'b1, 1'b0);
    send_dec();
    check("dec_ack_count", dec_ack_cnt, frm_q.size());
    check_rd("rd_dec_cnt1", 32'h10, 32'd1);

    // Reset in the middle of a frame abandons it without counting
    chk_en = 1'b0;
    @(posedge clk);
    #1;
    enc_cyc = 1'b1; enc_stb = 1'b1; {enc_adr, enc_sel, enc_we, enc_dat} = pack(2'd0, 2'd3, 1'b1, 16'h1234);
    @(posedge clk);
    #1;
    enc_stb = 1'b0;
    check("pre_rst_stb", {31'h0, enc_src_stb}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_src", {12'h0, enc_src_cyc, enc_src_stb, enc_src_adr, enc_src_dat}, 32'h0);
    @(posedge clk);
    #1;
    enc_cyc = 1'b0;
    repeat (3) @(posedge clk);
    check_rd("rd_enc_cnt_after_rst", 32'h0C, 32'h0);
    check_rd("rd_enc_en_after_rst", 32'h00, 32'h1);
    check_rd("rd_dmac_hi_after_rst", 32'h04, 32'h1122);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
